// File: rtl/prince_sbox_cms_sched.sv
// prince_sbox_cms_sched: nibble-serial scheduler for a pipelined CMS-masked
// PRINCE S-box datapath. It buffers a 64-bit state held in NSHARES Boolean
// shares and feeds one shared nibble per cycle into the single S-box instance.
// When fresh randomness is missing, every datapath stage is frozen together.
// The shared S-box outputs are collected back into a 64-bit shared result.
//
// Optional build macro: PRINCE_CMS_SCHED_ZEROIZE_EN
//   When defined, o_sb_in is driven to zero outside FEED, the input buffer is
//   cleared on entry to DONE, and o_result is cleared on an accepted start.
module prince_sbox_cms_sched #(
  parameter int NSHARES     = 3,
  parameter int PIPE_STAGES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [64*NSHARES-1:0]    i_state,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [64*NSHARES-1:0]    o_result,
  output logic [4*NSHARES-1:0]     o_sb_in,
  input  logic [4*NSHARES-1:0]     i_sb_out,
  output logic [PIPE_STAGES-1:0]   o_stage_en,
  output logic                     o_rnd_req,
  input  logic                     i_rnd_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [64*NSHARES-1:0]   in_buf;
  logic [4:0]              feed_cnt;
  logic [4:0]              out_cnt;
  logic [PIPE_STAGES-1:0]  valid_pipe;
  logic [4*NSHARES-1:0]    feed_nib;
  logic                    active;
  logic                    adv;
  logic                    capture;
  logic                    start_ok;
  logic                    feed_last;
  logic                    out_last;

  // Pipeline advance qualifiers: the whole datapath moves only with fresh masks.
  always_comb begin
    active    = (state == FEED) || (state == DRAIN);
    adv       = active && i_rnd_valid;
    capture   = adv && valid_pipe[PIPE_STAGES-1];
    start_ok  = (state == IDLE) && i_start;
    feed_last = (feed_cnt == 5'd15);
    out_last  = (out_cnt == 5'd15);
  end

  // Select nibble feed_cnt from every share of the buffered state.
  always_comb begin
    feed_nib = '0;
    for (int j = 0; j < NSHARES; j++) begin
      feed_nib[4*j +: 4] = in_buf[64*j + 4*int'(feed_cnt[3:0]) +: 4];
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps any path that does
    // not assign it from inferring a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (i_start) state_next = FEED;
      FEED:    if (adv && feed_last) state_next = DRAIN;
      DRAIN:   if (capture && out_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from values sampled before the edge.
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Feed/collect counters and the valid marker that follows each nibble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      feed_cnt   <= '0;
      out_cnt    <= '0;
      valid_pipe <= '0;
    end else if (start_ok) begin
      feed_cnt   <= '0;
      out_cnt    <= '0;
      valid_pipe <= '0;
    end else if (adv) begin
      if (state == FEED) feed_cnt <= feed_cnt + 5'd1;
      if (capture)       out_cnt  <= out_cnt + 5'd1;
      valid_pipe <= PIPE_STAGES'({valid_pipe, (state == FEED)});
    end
  end

  // Input share buffer: loaded on an accepted start.
  always_ff @(posedge i_clk) begin
    // NOTE: the share buffer is reset explicitly so no secret shares survive a
    // reset; this is a deliberate choice rather than a plain storage array.
    if (i_rst) begin
      in_buf <= '0;
    end else if (start_ok) begin
      in_buf <= i_state;
`ifdef PRINCE_CMS_SCHED_ZEROIZE_EN
    end else if ((state == DRAIN) && (state_next == DONE)) begin
      in_buf <= '0;
`endif
    end
  end

  // Result assembly: each captured datapath nibble lands at position out_cnt.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_result <= '0;
`ifdef PRINCE_CMS_SCHED_ZEROIZE_EN
    end else if (start_ok) begin
      o_result <= '0;
`endif
    end else if (capture) begin
      for (int j = 0; j < NSHARES; j++) begin
        o_result[64*j + 4*int'(out_cnt[3:0]) +: 4] <= i_sb_out[4*j +: 4];
      end
    end
  end

`ifdef PRINCE_CMS_SCHED_ZEROIZE_EN
  // Datapath input is live only while feeding; zero otherwise.
  always_comb begin
    o_sb_in = (state == FEED) ? feed_nib : '0;
  end
`else
  logic [4*NSHARES-1:0] last_nib;

  // Remember the last nibble that actually entered the datapath.
  always_ff @(posedge i_clk) begin
    if (i_rst)                        last_nib <= '0;
    else if (adv && (state == FEED))  last_nib <= feed_nib;
  end

  // Datapath input: current nibble while feeding, otherwise hold the last one.
  always_comb begin
    o_sb_in = (state == FEED) ? feed_nib : last_nib;
  end
`endif

  // Handshake and pipeline-control outputs.
  always_comb begin
    o_busy     = active;
    o_rnd_req  = active;
    o_done     = (state == DONE);
    o_stage_en = {PIPE_STAGES{adv}};
  end

endmodule

// File: tb/tb_prince_sbox_cms_sched.sv
// Testbench for prince_sbox_cms_sched: drives directed runs through a
// two-stage masked S-box model and checks results through a scoreboard queue
// drained by an independent o_done monitor.
module tb_prince_sbox_cms_sched;

  localparam int NSH = 3;
  localparam int PS  = 2;

  // Hand-computed PRINCE S-box layer outputs.
  localparam logic [63:0] X1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] R1 = 64'hBF32AC916780E5D4;
  localparam logic [63:0] X2 = 64'hFEDCBA9876543210;
  localparam logic [63:0] R2 = 64'h4D5E087619CA23FB;
  localparam logic [63:0] M1 = 64'h5A5A3C3CA5A5C3C3;
  localparam logic [63:0] M2 = 64'h0F1E2D3C4B5A6978;

  logic               clk = 1'b0;
  logic               i_rst;
  logic               i_start;
  logic [64*NSH-1:0]  i_state;
  logic               o_busy;
  logic               o_done;
  logic [64*NSH-1:0]  o_result;
  logic [4*NSH-1:0]   o_sb_in;
  logic [4*NSH-1:0]   i_sb_out;
  logic [PS-1:0]      o_stage_en;
  logic               o_rnd_req;
  logic               i_rnd_valid;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int t0       = 0;
  logic [191:0] prev_res = '0;

  typedef struct {
    logic [191:0] res;
    int           rel;
  } exp_t;
  exp_t sb_q[$];

  prince_sbox_cms_sched #(.NSHARES(NSH), .PIPE_STAGES(PS)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_state     (i_state),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_result    (o_result),
    .o_sb_in     (o_sb_in),
    .i_sb_out    (i_sb_out),
    .o_stage_en  (o_stage_en),
    .o_rnd_req   (o_rnd_req),
    .i_rnd_valid (i_rnd_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h4D5E087619CA23FB;  // entry k at nibble k
    return t[4*x +: 4];
  endfunction

  function automatic logic [63:0] unmask(input logic [191:0] r);
    return r[63:0] ^ r[127:64] ^ r[191:128];
  endfunction

  // Two-stage masked S-box model: shares 1/2 pass through, share 0 absorbs S(x).
  logic [11:0] s1_q, s2_q;
  always @(posedge clk) begin
    if (i_rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (o_stage_en[0])
        s1_q <= {o_sb_in[11:8], o_sb_in[7:4],
                 sbox(o_sb_in[3:0] ^ o_sb_in[7:4] ^ o_sb_in[11:8]) ^ o_sb_in[7:4] ^ o_sb_in[11:8]};
      if (o_stage_en[1])
        s2_q <= s1_q;
    end
  end
  assign i_sb_out = s2_q;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every o_done pops one expected response.
  always @(negedge clk) begin
    if (o_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", {191'b0, o_done}, 192'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_cycle", 192'(cyc - t0), 192'(e.rel));
        check("result_shares", o_result, e.res);
        check("result_unmasked", {128'b0, unmask(o_result)}, {128'b0, unmask(e.res)});
      end
    end
  end

  function automatic logic [191:0] shares(input logic [63:0] x, input logic [63:0] a, input logic [63:0] b);
    return {b, a, x ^ a ^ b};
  endfunction

  task automatic run(input logic [191:0] st, input logic [191:0] alt, input logic [63:0] stall,
                     input int sa, input int sb, input int rst_at,
                     input logic [191:0] exp_res, input int done_rel);
    bit   exp_done;
    bit   exp_busy;
    int   last;
    logic [11:0] drain_nib;
    exp_done  = (rst_at < 0);
    last      = exp_done ? done_rel + 2 : rst_at + 3;
    drain_nib = {st[191:188], st[127:124], st[63:60]};
`ifdef PRINCE_CMS_SCHED_ZEROIZE_EN
    drain_nib = '0;
`endif
    for (int rel = 0; rel <= last; rel++) begin
      @(posedge clk);
      #1;
      if (rel == 0) begin
        t0 = cyc;
        if (exp_done) sb_q.push_back('{res: exp_res, rel: done_rel});
      end
      i_start     = (rel == 0) || (rel == sa) || (rel == sb);
      i_state     = (rel == 0) ? st : alt;
      i_rnd_valid = !stall[rel];
      i_rst       = (rel == rst_at);
      @(negedge clk);
      exp_busy = (rel >= 1) && (rel < (exp_done ? done_rel : rst_at + 1));
      check("busy", {191'b0, o_busy}, {191'b0, exp_busy});
      check("rnd_req", {191'b0, o_rnd_req}, {191'b0, exp_busy});
      check("stage_en", {190'b0, o_stage_en}, (exp_busy && !stall[rel]) ? 192'd3 : 192'd0);
      if (rel == 1) begin
`ifdef PRINCE_CMS_SCHED_ZEROIZE_EN
        check("result_after_start", o_result, 192'b0);
`else
        check("result_after_start", o_result, prev_res);
`endif
      end
      if (exp_done && rel == done_rel - 1)
        check("sb_in_drain", {180'b0, o_sb_in}, {180'b0, drain_nib});
      if (exp_done && rel == done_rel + 1)
        check("sb_in_idle", {180'b0, o_sb_in}, {180'b0, drain_nib});
      if (!exp_done && rel == rst_at + 1) begin
        check("rst_result", o_result, 192'b0);
        check("rst_outputs", {176'b0, o_done, o_sb_in, o_stage_en, o_rnd_req},  192'b0);
      end
    end
    i_start = 1'b0;
    prev_res = exp_done ? exp_res : '0;
  endtask

  initial begin
    i_rst       = 1'b1;
    i_start     = 1'b0;
    i_state     = '0;
    i_rnd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_result", o_result, 192'b0);
      check("idle_outputs", {175'b0, o_busy, o_done, o_sb_in, o_stage_en, o_rnd_req}, 192'b0);
    end

    // Basic run: unmasked share 0 only.
    run(shares(X1, 64'h0, 64'h0), '0, 64'h0, -1, -1, -1, shares(R1, 64'h0, 64'h0), 19);
    // Masked shares with stalls in cycles 3, 4 and 17.
    run(shares(X1, M1, M2), '0, 64'h0002_0018, -1, -1, -1, shares(R1, M1, M2), 22);
    // Starts while busy (cycle 7) and in the done cycle (19) are ignored.
    run(shares(X1, M2, M1), shares(X2, M1, M1), 64'h0, 7, 19, -1, shares(R1, M2, M1), 19);
    // Reset in cycle 10 aborts the run.
    run(shares(X2, M1, M2), '0, 64'h0, -1, -1, 10, '0, 0);
    // Fresh run after the abort.
    run(shares(X2, M1, M2), '0, 64'h0, -1, -1, -1, shares(R2, M1, M2), 19);

    check("missed_done", 192'(sb_q.size()), 192'b0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prince_sbox_cms_sched.md
Name: prince_sbox_cms_sched

Overview:
Nibble-serial scheduler for the pipelined CMS-masked PRINCE S-box datapath (affine share layers plus registered quadratic layers).
- Accepts a full 64-bit PRINCE state in NSHARES Boolean shares.
- Feeds one shared nibble per cycle into the single S-box instance.
- Gates the datapath pipeline registers and stalls the whole pipeline when fresh randomness is unavailable.
- Reassembles the shared S-box outputs into a 64-bit shared result; sits between the round-function controller and the S-box datapath.

Parameters:
NSHARES, 3, number of Boolean shares per bit (minimum 2).
PIPE_STAGES, 2, register stages inside the S-box datapath (one per quadratic layer); range 1..4.

Ports:
i_clk  input  1  clock; all state changes on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_start  input  1  one-cycle request to process i_state; honoured only in IDLE.
i_state  input  64*NSHARES  shared input state; share j occupies bits [64j+63:64j]; sampled on the accepted i_start edge.
o_busy  output  1  high in FEED and DRAIN.
o_done  output  1  one-cycle pulse when o_result is complete.
o_result  output  64*NSHARES  shared S-box layer output; same packing as i_state.
o_sb_in  output  4*NSHARES  nibble to the datapath; share j occupies bits [4j+3:4j].
i_sb_out  input  4*NSHARES  datapath output nibble, same packing.
o_stage_en  output  PIPE_STAGES  clock enable for each datapath register stage.
o_rnd_req  output  1  requests fresh mask bits for the current cycle.
i_rnd_valid  input  1  fresh randomness present this cycle.

Behaviour:
- Reset: state IDLE; o_busy=0, o_done=0, o_result=0, o_sb_in=0, o_stage_en=0, o_rnd_req=0; feed/collect counters and valid pipe cleared. Reset mid-operation aborts immediately. No partial result is retained.
- Nibble k is bits [4k+3:4k] of each share, processed in order k=0..15. Output nibble k is written to the same position.
- States:
  - IDLE: i_start=1 latches i_state into the input buffer, clears feed_cnt/out_cnt, goes to FEED. i_start while not IDLE is ignored.
  - FEED: o_sb_in = buffered nibble feed_cnt. The cycle advances (adv=1) only when i_rnd_valid=1. On adv: feed_cnt++ and a 1 is shifted into valid_pipe[PIPE_STAGES-1:0]. After nibble 15 advances, go to DRAIN.
  - DRAIN: o_sb_in holds its last value; adv=i_rnd_valid; a 0 is shifted into valid_pipe on adv. When out_cnt reaches 16, go to DONE.
  - DONE: o_done=1 for exactly one cycle, o_busy=0, then IDLE. o_result stays stable until the next accepted start.
- o_rnd_req = 1 in FEED and DRAIN; 0 otherwise.
- o_stage_en = {PIPE_STAGES{adv}}. All stages freeze together during a stall, so shares stay in their registers and no nibble is duplicated or dropped.
- Capture: when adv=1 and valid_pipe MSB=1, i_sb_out is written to nibble out_cnt of o_result and out_cnt++. Capture happens in both FEED and DRAIN.
- Timing with no stalls: start edge at cycle 0; FEED occupies cycles 1..16; output nibble k is captured at the end of cycle 1+k+PIPE_STAGES; o_done is high in cycle 17+PIPE_STAGES (cycle 19 with default parameters).
- Each stall cycle (i_rnd_valid=0 in FEED/DRAIN) delays o_done by exactly one cycle.
- Counters are 5 bits; no wrap past 16. i_start coincident with o_done is ignored (state is DONE, not IDLE).

Optional Feature:
PRINCE_CMS_SCHED_ZEROIZE_EN
- Defined:
  - o_sb_in is forced to 0 outside FEED.
  - The input buffer is cleared on entry to DONE.
  - o_result is cleared on an accepted i_start, before new captures.
- Undefined: o_sb_in holds the last fed nibble, and the buffer and o_result keep stale shares until overwritten.
- All other timing is identical in both builds.

Test Plan:
- Reset/idle: i_rst=1 for 2 cycles, then idle 5 cycles -> all outputs 0; o_stage_en=0.
- Basic run: NSHARES=3, PIPE_STAGES=2, share0=0x0123456789ABCDEF, shares1/2=0, bench S-box model with 2-cycle latency, i_rnd_valid=1 -> o_done only in cycle 19; XOR of o_result shares = 0x0123456789ABCDEF mapped nibble-wise through the PRINCE S-box 0xB,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4; busy cycles 1..18.
- Stalls: same stimulus with i_rnd_valid=0 in cycles 3,4 and 17 -> o_stage_en=0 in exactly those cycles; o_done in cycle 22; result identical to the basic run.
- Start while busy: i_start pulse in cycle 7 with different i_state -> ignored; result as in the basic run; i_start in the o_done cycle is also ignored.
- Reset mid-run: i_rst in cycle 10 -> next cycle IDLE, all outputs 0; a fresh start completes normally in 19 cycles.
- Zeroize build: macro defined -> o_sb_in=0 in IDLE/DRAIN/DONE, and o_result=0 in the cycle after an accepted start; macro undefined -> o_sb_in equals nibble 15 in DRAIN.
